// File: rtl/bsg_pkg.sv
// Shared types and constants for the BSG transmit path.
// Register map and control-bit positions are used by the bus register block.
package bsg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } bsg_state_t;

  localparam int BSG_NBITS = 16;

  localparam logic [7:0] BSG_ADDR_CTRL  = 8'd10;
  localparam logic [7:0] BSG_ADDR_DATA1 = 8'd11;
  localparam logic [7:0] BSG_ADDR_DATA2 = 8'd12;

  localparam int TXENABLE = 0;
  localparam int INTMSK   = 1;
  localparam int INTFLAG  = 2;
  localparam int STATUS   = 3;

endpackage

// File: rtl/bsg_baud_tick.sv
// Bit-period divider: counts 0..CLK_DIV-1 while enabled and pulses tick
// on the terminal count so the sequencer advances one bit per period.
module bsg_baud_tick
  import bsg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] div_cnt_r;
  logic             last_s;

  assign last_s = (div_cnt_r == DIV_LAST);
  assign tick   = en & last_s;

  // Divider counter; only advances while the sequencer is shifting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_r <= '0;
    end else if (clr) begin
      div_cnt_r <= '0;
    end else if (en) begin
      if (last_s) begin
        div_cnt_r <= '0;
      end else begin
        div_cnt_r <= div_cnt_r + DIV_ONE;
      end
    end else begin
      div_cnt_r <= div_cnt_r;
    end
  end

endmodule

// File: rtl/bsg_tx_ctrl.sv
// BSG transmit sequencer: latches {data1,data2} and shifts it out MSB first,
// driving STATUS (busy), a done pulse and the sticky INTFLAG.
module bsg_tx_ctrl
  import bsg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_enable,
  input  logic       int_mask,
  input  logic       int_clr,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       done,
  output logic       int_flag
);

  localparam logic [3:0] BIT_LAST = 4'(BSG_NBITS - 1);

  bsg_state_t           state_r, state_s;
  logic [BSG_NBITS-1:0] shreg_r, shreg_s;
  logic [3:0]           bit_cnt_r, bit_cnt_s;
  logic                 tx_out_r, tx_out_s;
  logic                 tx_busy_r, tx_busy_s;
  logic                 done_r, done_s;
  logic                 int_flag_r, int_flag_s;
  logic                 tick_s;

  bsg_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_r == LOAD),
    .en    (state_r == SHIFT),
    .tick  (tick_s)
  );

  // Next-state, datapath and next-output logic; outputs are derived from the
  // next state so they register in step with it.
  always_comb begin
    state_s    = state_r;
    shreg_s    = shreg_r;
    bit_cnt_s  = bit_cnt_r;
    int_flag_s = int_flag_r;
    case (state_r)
      IDLE: begin
        if (tx_enable) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        shreg_s   = {data1, data2};
        bit_cnt_s = 4'd0;
        state_s   = SHIFT;
      end
      SHIFT: begin
        if (tick_s) begin
          shreg_s   = {shreg_r[BSG_NBITS-2:0], 1'b0};
          bit_cnt_s = bit_cnt_r + 4'd1;
          if (bit_cnt_r == BIT_LAST) begin
            state_s = DONE;
          end else begin
            state_s = SHIFT;
          end
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Set from a completed, unmasked frame takes priority over a bus clear.
    if ((state_r == DONE) && int_mask) begin
      int_flag_s = 1'b1;
    end else if (int_clr) begin
      int_flag_s = 1'b0;
    end else begin
      int_flag_s = int_flag_r;
    end

    tx_out_s  = (state_s == SHIFT) ? shreg_s[BSG_NBITS-1] : 1'b1;
    tx_busy_s = (state_s != IDLE);
    done_s    = (state_s == DONE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      shreg_r    <= 16'h0000;
      bit_cnt_r  <= 4'd0;
      tx_out_r   <= 1'b1;
      tx_busy_r  <= 1'b0;
      done_r     <= 1'b0;
      int_flag_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      shreg_r    <= shreg_s;
      bit_cnt_r  <= bit_cnt_s;
      tx_out_r   <= tx_out_s;
      tx_busy_r  <= tx_busy_s;
      done_r     <= done_s;
      int_flag_r <= int_flag_s;
    end
  end

  assign tx_out   = tx_out_r;
  assign tx_busy  = tx_busy_r;
  assign done     = done_r;
  assign int_flag = int_flag_r;

endmodule

// File: tb/tb_bsg_tx_ctrl.sv
// Randomized self-checking bench for bsg_tx_ctrl at CLK_DIV=4 and CLK_DIV=1,
// using a cycle-offset timing model of one frame.
module tb_bsg_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, en, sel, int_mask, int_clr;
  logic [7:0] data1, data2;
  logic       en0, en1;
  logic       tx_out0, busy0, done0, flag0;
  logic       tx_out1, busy1, done1, flag1;
  logic       obs_tx, obs_busy, obs_done, obs_flag;
  int         total = 0;
  int         bad = 0;
  bit         exp_flag = 1'b0;

  always #5 clk = ~clk;

  assign en0      = en & ~sel;
  assign en1      = en & sel;
  assign obs_tx   = sel ? tx_out1 : tx_out0;
  assign obs_busy = sel ? busy1 : busy0;
  assign obs_done = sel ? done1 : done0;
  assign obs_flag = sel ? flag1 : flag0;

  bsg_tx_ctrl #(.CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .tx_enable(en0), .int_mask(int_mask), .int_clr(int_clr),
    .data1(data1), .data2(data2), .tx_out(tx_out0), .tx_busy(busy0), .done(done0),
    .int_flag(flag0)
  );

  bsg_tx_ctrl #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_enable(en1), .int_mask(int_mask), .int_clr(int_clr),
    .data1(data1), .data2(data2), .tx_out(tx_out1), .tx_busy(busy1), .done(done1),
    .int_flag(flag1)
  );

  // Raises tx_enable at a negedge and checks every cycle of the frame.
  // Sample j is taken after the j-th edge following the request.
  task automatic check_frame(input logic [15:0] frame, input int d, input bit mask,
                             input bit hold, input int chg_j, input int clr_j);
    int n = 3 + 16 * d;
    int busy_cnt = 0;
    logic exp_tx, exp_busy, exp_done;
    en = 1'b1;
    int_mask = mask;
    for (int j = 1; j <= n; j++) begin
      @(posedge clk);
      if (j == n && mask) exp_flag = 1'b1;
      else if (int_clr) exp_flag = 1'b0;
      @(negedge clk);
      if (j == 1) begin
        exp_tx = 1'b1; exp_busy = 1'b1; exp_done = 1'b0;
      end else if (j <= 1 + 16 * d) begin
        exp_tx = frame[15 - (j - 2) / d]; exp_busy = 1'b1; exp_done = 1'b0;
      end else if (j == 2 + 16 * d) begin
        exp_tx = 1'b1; exp_busy = 1'b1; exp_done = 1'b1;
      end else begin
        exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
      end
      total++;
      if (obs_tx !== exp_tx) begin
        bad++; $display("FAIL tx_out d=%0d j=%0d got=%b exp=%b", d, j, obs_tx, exp_tx);
      end
      total++;
      if (obs_busy !== exp_busy) begin
        bad++; $display("FAIL tx_busy d=%0d j=%0d got=%b exp=%b", d, j, obs_busy, exp_busy);
      end
      total++;
      if (obs_done !== exp_done) begin
        bad++; $display("FAIL done d=%0d j=%0d got=%b exp=%b", d, j, obs_done, exp_done);
      end
      total++;
      if (obs_flag !== exp_flag) begin
        bad++; $display("FAIL int_flag d=%0d j=%0d got=%b exp=%b", d, j, obs_flag, exp_flag);
      end
      if (obs_busy === 1'b1) busy_cnt++;
      if (!hold && j == 1) en = 1'b0;
      if (j == chg_j) data1 = 8'hFF;
      int_clr = (j == clr_j);
    end
    total++;
    if (busy_cnt != 2 + 16 * d) begin
      bad++; $display("FAIL busy_len d=%0d got=%0d exp=%0d", d, busy_cnt, 2 + 16 * d);
    end
  endtask

  task automatic clear_flag();
    int_clr = 1'b1;
    @(posedge clk);
    exp_flag = 1'b0;
    @(negedge clk);
    int_clr = 1'b0;
    total++;
    if (obs_flag !== exp_flag) begin
      bad++; $display("FAIL flag_clear got=%b exp=%b", obs_flag, exp_flag);
    end
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst_n = 1'b0; en = 1'b0; sel = 1'b0; int_mask = 1'b0; int_clr = 1'b0;
    data1 = 8'h00; data2 = 8'h00;
    repeat (3) @(negedge clk);
    got = {tx_out0, busy0, done0, flag0, tx_out1, busy1, done1, flag1};
    for (int i = 0; i < 8; i++) begin
      total++;
      if (got[7 - i] !== ((i % 4) == 0)) begin
        bad++; $display("FAIL reset_out idx=%0d got=%b exp=%b", i, got[7 - i], (i % 4) == 0);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    data1 = 8'hA5; data2 = 8'h3C;
    check_frame(16'hA53C, 4, 1'b1, 1'b0, -1, -1);
  endtask

  task automatic test_masked();
    logic [15:0] f;
    // Masked frame with the flag already set, then with it clear.
    for (int k = 0; k < 2; k++) begin
      if (k == 1) clear_flag();
      f = 16'($urandom); data1 = f[15:8]; data2 = f[7:0];
      check_frame(f, 4, 1'b0, 1'b0, -1, -1);
    end
  endtask

  task automatic test_clear_collision();
    logic [15:0] f;
    f = 16'($urandom); data1 = f[15:8]; data2 = f[7:0];
    check_frame(f, 4, 1'b1, 1'b0, -1, -1);
    clear_flag();
    f = 16'($urandom); data1 = f[15:8]; data2 = f[7:0];
    check_frame(f, 4, 1'b1, 1'b0, -1, 2 + 16 * 4);
  endtask

  task automatic test_back_to_back();
    logic [15:0] f;
    bit m;
    f = 16'($urandom); data1 = f[15:8]; data2 = f[7:0];
    m = 1'($urandom_range(0, 1));
    check_frame(f, 4, m, 1'b1, 20, -1);
    check_frame({8'hFF, f[7:0]}, 4, m, 1'b0, -1, -1);
  endtask

  task automatic test_reset_mid();
    logic [15:0] f;
    f = 16'($urandom); data1 = f[15:8]; data2 = f[7:0];
    check_frame(f, 4, 1'b1, 1'b0, -1, -1);
    en = 1'b1;
    for (int j = 1; j <= 2 + 8 * 4; j++) begin
      @(negedge clk);
      if (j == 1) en = 1'b0;
    end
    rst_n = 1'b0;
    @(posedge clk);
    exp_flag = 1'b0;
    @(negedge clk);
    total++;
    if ({tx_out0, busy0, done0, flag0} !== 4'b1000) begin
      bad++; $display("FAIL reset_mid got=%b exp=1000", {tx_out0, busy0, done0, flag0});
    end
    rst_n = 1'b1;
    @(negedge clk);
    f = 16'($urandom); data1 = f[15:8]; data2 = f[7:0];
    check_frame(f, 4, 1'($urandom_range(0, 1)), 1'b0, -1, -1);
  endtask

  task automatic test_div1();
    logic [15:0] f;
    clear_flag();
    sel = 1'b1;
    for (int k = 0; k < 3; k++) begin
      f = 16'($urandom); data1 = f[15:8]; data2 = f[7:0];
      check_frame(f, 1, 1'($urandom_range(0, 1)), 1'b0, -1, -1);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_masked();
    test_clear_collision();
    test_back_to_back();
    test_reset_mid();
    test_div1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
